avalon_data_bus: RTL and testbench
==================================

# avalon_data_bus

Memory-mapped data-side slave for the 16-bit pipelined processor, speaking a simplified Avalon-MM protocol with wait-request. It contains a 4K-word data RAM, a free-running cycle counter and a scratch register, decoded from a 16-bit word address. Writes complete in zero wait states. Reads take exactly one wait state. The processor stalls on `Waitreq` and uses `~Waitreq` as its data-valid/accept indication.

## Interface
- No parameters; all sizes are fixed.
- `Clock`: input, 1 bit. Single clock; everything is rising-edge.
- `Reset`: input, 1 bit. Asynchronous, active-low reset.
- `Read`: input, 1 bit. Read request; the master holds it until accepted.
- `Write`: input, 1 bit. Write request.
- `WrData`: input, 16 bits. Write data from the master (processor `DataOut`).
- `Addr`: input, 16 bits. Word address (processor `DataAddr`).
- `RdData`: output, 16 bits. Read data to the master (processor `DataIn`).
- `Waitreq`: output, 1 bit. When 1, the master must hold its request.

## Operation
- Address map:
  - `0x0000–0x0FFF`: data RAM, 4096×16, synchronous, initialised to 0 at configuration. Reset does not clear it.
  - `0xF000`: cycle counter, read-only. 16 bits, +1 every clock, wraps `0xFFFF→0x0000`. Writes are ignored.
  - `0xF001`: scratch register, read/write.
  - All other addresses: reads return `0x0000`, writes are ignored. These accesses still complete normally with no error.
- FSM states:
  - IDLE:
    - `Write=1`: `Waitreq=0`. The addressed location is written at this edge. The transaction is done and the state stays IDLE.
    - `Read=1, Write=0`: `Waitreq=1`. `Addr` is latched and the source is sampled at this edge (RAM word, counter value, scratch or 0). Go to RD_DONE.
    - Neither asserted: `Waitreq=0`.
  - RD_DONE:
    - `Waitreq=0` and `RdData` = latched value. The read completes at this edge.
    - Always return to IDLE, regardless of inputs.
- `Read` and `Write` both 1 in IDLE: the write wins and the read is ignored for that cycle.
- Inputs in RD_DONE are not decoded. A `Read` still high afterwards starts a new transaction in IDLE, so back-to-back reads take 2 cycles each.
- The latched address is used. Changes to `Addr` during the wait cycle have no effect.
- `RdData` holds its last value between reads.
- Reset asserted:
  - State forced to IDLE, `RdData=0`, counter=0, scratch=0.
  - `Waitreq` is forced to 1, so the master stalls.
  - A read in progress is aborted and its data discarded.

## Timing
- Write latency: 0 wait states. Data is visible to a read that starts on the next cycle.
- Read latency: 1 wait state. The request is seen at edge N with `Waitreq=1`. Data is valid with `Waitreq=0` during cycle N+1 and is accepted at edge N+1.
- Counter read value: the value present at edge N, i.e. when the request is first sampled.
- Read-after-write to the same address on consecutive cycles returns the new data.
- `Waitreq` is combinational from state, `Read`, `Write` and `Reset`. `RdData` is registered.
- Reset deassertion: normal operation starts at the first rising edge after `Reset` goes high.

## Test plan
- Reset, then write `0x1234` to `0x0005` with no wait; read `0x0005`. Expect `Waitreq` 1 for one cycle, then `RdData=0x1234` with `Waitreq=0`.
- Write `0xAAAA` to `0x0FFF` and `0x5555` to `0x0000`, then read both. Expect the correct data at each end of the RAM and no aliasing.
- Hold `Read=1` on `0xF000` for 6 cycles. Expect 3 completions whose counter values differ by exactly 2. Force a counter wrap and check `0xFFFF→0x0000`.
- Write `0xBEEF` to `0xF001` and read it back to get `0xBEEF`. Write to `0xF000` and to `0x2000`: both are ignored, and reads of `0x2000` return `0x0000`.
- Assert `Read` and `Write` together on `0x0010` with `0x7777`. Expect `Waitreq=0`, the write performed, and no read issued.
- Assert `Reset` low in RD_DONE. Expect `Waitreq=1` and `RdData=0` immediately, then IDLE after release. RAM contents written before reset survive.

Source files
------------

// File: rtl/avalon_data_bus.sv
// Data-side Avalon-MM slave: 4K x 16 RAM, free-running cycle counter and scratch register.
// Zero-wait-state writes, single-wait-state reads with a registered read-data path.
module avalon_data_bus (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [15:0] WrData,
  input  logic [15:0] Addr,
  output logic [15:0] RdData,
  output logic        Waitreq
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_DONE = 1'b1
  } state_t;

  localparam logic [15:0] CNT_ADDR = 16'hF000;
  localparam logic [15:0] SCR_ADDR = 16'hF001;

  state_t      state_r;
  logic [15:0] count_r;
  logic [15:0] scratch_r;
  logic [15:0] other_q_r;
  logic        use_ram_r;
  logic [15:0] ram_q_r;
  logic [15:0] mem_r [0:4095];

  logic        ram_sel_s;
  logic        cnt_sel_s;
  logic        scr_sel_s;
  logic        wr_go_s;
  logic        rd_go_s;
  logic [15:0] other_src_s;

  // Address decode and transaction acceptance in IDLE
  always_comb begin
    ram_sel_s   = (Addr[15:12] == 4'h0);
    cnt_sel_s   = (Addr == CNT_ADDR);
    scr_sel_s   = (Addr == SCR_ADDR);
    wr_go_s     = Reset && (state_r == IDLE) && Write;
    rd_go_s     = Reset && (state_r == IDLE) && Read && !Write;
    other_src_s = 16'h0000;
    if (cnt_sel_s) begin
      other_src_s = count_r;
    end else if (scr_sel_s) begin
      other_src_s = scratch_r;
    end else begin
      other_src_s = 16'h0000;
    end
  end

  // Wait-request: stall during reset and in the accept cycle of a read
  always_comb begin
    Waitreq = 1'b1;
    if (!Reset) begin
      Waitreq = 1'b1;
    end else begin
      case (state_r)
        IDLE:    Waitreq = Read && !Write;
        RD_DONE: Waitreq = 1'b0;
        default: Waitreq = 1'b1;
      endcase
    end
  end

  // RAM array has no reset so it can map onto block memory; its read port only moves on an accepted RAM read
  always_ff @(posedge Clock) begin
    if (wr_go_s && ram_sel_s) begin
      mem_r[Addr[11:0]] <= WrData;
    end
    if (rd_go_s && ram_sel_s) begin
      ram_q_r <= mem_r[Addr[11:0]];
    end
  end

  // Free-running cycle counter
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_r <= 16'h0000;
    end else begin
      count_r <= count_r + 16'd1;
    end
  end

  // Scratch register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      scratch_r <= 16'h0000;
    end else if (wr_go_s && scr_sel_s) begin
      scratch_r <= WrData;
    end
  end

  // Read FSM; the non-RAM snapshot and source select are captured when the read is accepted
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r   <= IDLE;
      other_q_r <= 16'h0000;
      use_ram_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_go_s) begin
            other_q_r <= other_src_s;
            use_ram_r <= ram_sel_s;
            state_r   <= RD_DONE;
          end else begin
            state_r   <= IDLE;
          end
        end
        RD_DONE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Both sources are registers, so RdData holds between reads and is zero straight out of reset
  always_comb begin
    if (use_ram_r) begin
      RdData = ram_q_r;
    end else begin
      RdData = other_q_r;
    end
  end

endmodule

// File: tb/tb_avalon_data_bus.sv
// Directed self-checking bench for avalon_data_bus.
// Inputs change on the falling edge; outputs are checked shortly after it.
module tb_avalon_data_bus;

  logic        Clock;
  logic        Reset;
  logic        Read;
  logic        Write;
  logic [15:0] WrData;
  logic [15:0] Addr;
  logic [15:0] RdData;
  logic        Waitreq;

  int checks = 0;
  int errors = 0;
  logic [15:0] cnt_model;

  avalon_data_bus dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Read    (Read),
    .Write   (Write),
    .WrData  (WrData),
    .Addr    (Addr),
    .RdData  (RdData),
    .Waitreq (Waitreq)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference cycle count: zero in reset, +1 per rising edge
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) cnt_model <= 16'h0000;
    else        cnt_model <= cnt_model + 16'd1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge
  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    Write = 1'b1; Addr = a; WrData = d;
    #1 check("wr_waitreq", {15'd0, Waitreq}, 16'h0000);
    @(negedge Clock);
    Write = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
    Read = 1'b1; Addr = a;
    #1 check({tag, "_wait"}, {15'd0, Waitreq}, 16'h0001);
    @(negedge Clock);
    Addr = 16'hDEAD;
    #1 check({tag, "_done"}, {15'd0, Waitreq}, 16'h0000);
    check({tag, "_data"}, RdData, exp);
    Read = 1'b0;
    @(negedge Clock);
    #1 check({tag, "_hold"}, RdData, exp);
  endtask

  // Hold Read on the counter for six cycles: three completions, two cycles apart
  task automatic hold_read(input string tag);
    logic [15:0] c0;
    logic [15:0] exp;
    int done;
    c0 = cnt_model;
    done = 0;
    Read = 1'b1; Addr = 16'hF000;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clock);
      #1;
      if (i % 2 == 1) begin
        exp = c0 + 16'(i - 1);
        check({tag, "_wr0"}, {15'd0, Waitreq}, 16'h0000);
        check({tag, "_val"}, RdData, exp);
        if (Waitreq === 1'b0) done++;
      end else begin
        check({tag, "_wr1"}, {15'd0, Waitreq}, 16'h0001);
      end
    end
    Read = 1'b0;
    check({tag, "_count"}, 16'(done), 16'd3);
    @(negedge Clock);
  endtask

  initial begin
    int n;
    Reset = 1'b0; Read = 1'b0; Write = 1'b0; WrData = 16'h0000; Addr = 16'h0000;
    repeat (2) @(negedge Clock);
    #1 check("rst_waitreq", {15'd0, Waitreq}, 16'h0001);
    check("rst_rddata", RdData, 16'h0000);
    @(negedge Clock);
    Reset = 1'b1;
    #1 check("idle_waitreq", {15'd0, Waitreq}, 16'h0000);
    @(negedge Clock);

    do_write(16'h0005, 16'h1234);
    do_read("raw_0005", 16'h0005, 16'h1234);

    do_write(16'h0FFF, 16'hAAAA);
    do_write(16'h0000, 16'h5555);
    do_read("ram_top", 16'h0FFF, 16'hAAAA);
    do_read("ram_bot", 16'h0000, 16'h5555);
    do_read("ram_mid", 16'h0005, 16'h1234);

    hold_read("cnt_hold");

    do_write(16'hF001, 16'hBEEF);
    do_read("scratch", 16'hF001, 16'hBEEF);

    // Simultaneous read and write: write wins, no read is started
    Read = 1'b1; Write = 1'b1; Addr = 16'h0010; WrData = 16'h7777;
    #1 check("rw_waitreq", {15'd0, Waitreq}, 16'h0000);
    @(negedge Clock);
    Write = 1'b0;
    #1 check("rw_noread_wait", {15'd0, Waitreq}, 16'h0001);
    check("rw_noread_data", RdData, 16'hBEEF);
    @(negedge Clock);
    #1 check("rw_written", RdData, 16'h7777);
    check("rw_done", {15'd0, Waitreq}, 16'h0000);
    Read = 1'b0;
    @(negedge Clock);

    do_write(16'hF000, 16'h5A5A);
    do_read("cnt_ro", 16'hF000, cnt_model);
    do_write(16'h2000, 16'h9999);
    do_read("unmap_2000", 16'h2000, 16'h0000);
    do_read("unmap_1000", 16'h1000, 16'h0000);

    // Reset during the data cycle of a read
    Read = 1'b1; Addr = 16'h0005;
    @(negedge Clock);
    Reset = 1'b0; Read = 1'b0;
    #1 check("rd_rst_wait", {15'd0, Waitreq}, 16'h0001);
    check("rd_rst_data", RdData, 16'h0000);
    @(negedge Clock);
    #1 check("rd_rst_wait2", {15'd0, Waitreq}, 16'h0001);
    Reset = 1'b1;
    #1 check("rd_rst_idle", {15'd0, Waitreq}, 16'h0000);
    @(negedge Clock);
    do_read("keep_0005", 16'h0005, 16'h1234);
    do_read("keep_0fff", 16'h0FFF, 16'hAAAA);
    do_read("scr_cleared", 16'hF001, 16'h0000);
    do_read("cnt_restart", 16'hF000, cnt_model);

    // Run up to the counter wrap and read across it
    n = 0;
    while (cnt_model != 16'hFFFE && n < 70000) begin
      @(negedge Clock);
      n++;
    end
    check("wrap_reach", cnt_model, 16'hFFFE);
    hold_read("cnt_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
